// File: rtl/silife_pkg.sv
// Shared types and width helpers for the silife readout/statistics blocks.
package silife_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Row-index width; a single-row grid still needs one bit.
  function automatic int idx_w(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

  // Population-count width large enough to hold an all-live grid.
  function automatic int cnt_w(input int width, input int height);
    return $clog2(width * height + 1);
  endfunction

endpackage

// File: rtl/silife_popcount.sv
// Combinational population count of one row of cells.
module silife_popcount #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int PW = $clog2(WIDTH + 1);

  // Sum the live bits of the row.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/silife_grid_reader.sv
// Captures the cell matrix in one cycle and streams it out row by row over
// a valid/ready handshake, accumulating the snapshot's live-cell total.
module silife_grid_reader
  import silife_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [WIDTH*HEIGHT-1:0]             cells,
  output logic                                busy,
  output logic [WIDTH-1:0]                    row_data,
  output logic [$clog2(HEIGHT)-1:0]           row_index,
  output logic                                row_last,
  output logic                                row_valid,
  input  logic                                row_ready,
  output logic                                done,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]   live_count
);

  localparam int IW = idx_w(HEIGHT);
  localparam int CW = cnt_w(WIDTH, HEIGHT);
  localparam int PW = $clog2(WIDTH + 1);

  state_t                    state;
  state_t                    state_nx;
  logic [WIDTH*HEIGHT-1:0]   snap;
  logic [IW-1:0]             row_ptr;
  logic [CW-1:0]             acc;
  logic [CW-1:0]             acc_nx;
  logic [PW-1:0]             row_pop;
  logic                      at_last;
  logic                      xfer;

  assign at_last = (row_ptr == IW'(HEIGHT - 1));
  assign xfer    = (state == ST_SEND) && row_ready;
  assign acc_nx  = acc + CW'(row_pop);

  silife_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .bits  (row_data),
    .count (row_pop)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and output decode from registered state only.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    row_index = '0;
    row_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_SEND;
      end
      ST_SEND: begin
        busy      = 1'b1;
        row_valid = 1'b1;
        row_data  = snap[int'(row_ptr)*WIDTH +: WIDTH];
        row_index = row_ptr;
        row_last  = at_last;
        if (row_ready && at_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Snapshot capture, row pointer advance, accumulation and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap       <= '0;
      row_ptr    <= '0;
      acc        <= '0;
      live_count <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE && start) begin
        snap    <= cells;
        row_ptr <= '0;
        acc     <= '0;
      end else if (xfer) begin
        acc <= acc_nx;
        if (at_last) begin
          live_count <= acc_nx;
          done       <= 1'b1;
        end else begin
          row_ptr <= row_ptr + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_silife_grid_reader.sv
// Directed bench for silife_grid_reader with the default 8x8 grid.
module tb_silife_grid_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] cells;
  logic        busy;
  logic [7:0]  row_data;
  logic [2:0]  row_index;
  logic        row_last;
  logic        row_valid;
  logic        row_ready;
  logic        done;
  logic [6:0]  live_count;

  int n_chk  = 0;
  int n_fail = 0;

  silife_grid_reader #(.WIDTH(8), .HEIGHT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cells      (cells),
    .busy       (busy),
    .row_data   (row_data),
    .row_index  (row_index),
    .row_last   (row_last),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .done       (done),
    .live_count (live_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] cells;      // grid presented at the start edge
    logic [15:0] pat;        // row_ready pattern, bit k used on stream cycle k%16
    bit          flip;       // drive cells to all-ones right after capture
    bit          start_busy; // pulse start while streaming row 3
    bit          chain;      // assert start on the done cycle for the next record
    logic [63:0] exp_rows;   // expected rows, row r in bits [8r +: 8]
    logic [6:0]  exp_cnt;    // expected live_count
  } vec_t;

  vec_t vecs[9];
  bit   pre_started;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream one snapshot; on entry we are at a negedge.
  task automatic run_stream(input vec_t v, input bit pre, input logic [63:0] next_cells);
    int          idx;
    int          k;
    bit          stalled;
    logic [7:0]  prev_data;
    logic [2:0]  prev_idx;
    logic [7:0]  exp_row;
    logic [63:0] er;
    er      = v.exp_rows;
    idx     = 0;
    k       = 0;
    stalled = 1'b0;
    prev_data = '0;
    prev_idx  = '0;
    if (!pre) begin
      cells = v.cells;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    while (idx < 8 && k < 200) begin
      exp_row = er[idx*8 +: 8];
      chk("valid", row_valid, 1'b1);
      chk("busy", busy, 1'b1);
      chk("done_low", done, 1'b0);
      chk("row_index", row_index, idx[2:0]);
      chk("row_data", row_data, exp_row);
      chk("row_last", row_last, (idx == 7));
      if (stalled) begin
        chk("stall_data", row_data, prev_data);
        chk("stall_index", row_index, prev_idx);
      end
      prev_data = row_data;
      prev_idx  = row_index;
      row_ready = v.pat[k % 16];
      stalled   = !row_ready;
      start     = (v.start_busy && idx == 3) ? 1'b1 : 1'b0;
      if (v.flip && k == 0) cells = '1;
      @(posedge clk);
      if (row_ready) idx++;
      k++;
      @(negedge clk);
    end
    if (k >= 200) chk("stream_timeout", k, 0);
    if (v.pat == 16'hFFFF) chk("done_latency", k, 8);
    chk("done_pulse", done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("valid_end", row_valid, 1'b0);
    chk("live_count", live_count, v.exp_cnt);
    row_ready = 1'b0;
    if (v.chain) begin
      cells = next_cells;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end else begin
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("done_single", done, 1'b0);
      chk("busy_after", busy, 1'b0);
      chk("live_hold", live_count, v.exp_cnt);
    end
  endtask

  localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;

  initial begin
    vecs[0] = '{GLIDER, 16'hFFFF, 1'b0, 1'b0, 1'b0, GLIDER, 7'd5};
    vecs[1] = '{GLIDER, 16'h9999, 1'b0, 1'b0, 1'b0, GLIDER, 7'd5};
    vecs[2] = '{GLIDER, 16'hFFFF, 1'b1, 1'b0, 1'b0, GLIDER, 7'd5};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 7'd64};
    vecs[4] = '{GLIDER, 16'h9999, 1'b0, 1'b1, 1'b0, GLIDER, 7'd5};
    vecs[5] = '{GLIDER, 16'hFFFF, 1'b0, 1'b0, 1'b1, GLIDER, 7'd5};
    vecs[6] = '{64'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 64'h0, 7'd0};
    vecs[7] = '{64'h00FF_00FF_00FF_00FF, 16'h5555, 1'b0, 1'b0, 1'b0,
                64'h00FF_00FF_00FF_00FF, 7'd32};
    vecs[8] = '{64'h8000_0000_0000_0001, 16'hFFFF, 1'b0, 1'b0, 1'b0,
                64'h8000_0000_0000_0001, 7'd2};

    reset     = 1'b1;
    start     = 1'b0;
    cells     = '0;
    row_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", row_valid, 1'b0);
    chk("rst_last", row_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", row_data, 8'h00);
    chk("rst_index", row_index, 3'd0);
    chk("rst_live", live_count, 7'd0);
    reset = 1'b0;

    pre_started = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_stream(vecs[i], pre_started, (i < 8) ? vecs[i+1].cells : 64'h0);
      pre_started = vecs[i].chain;
    end

    // Reset after three transfers aborts the stream without a done pulse.
    cells     = GLIDER;
    start     = 1'b1;
    row_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_reset_index", row_index, 3'd3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", row_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_live", live_count, 7'd0);
    chk("abort_data", row_data, 8'h00);
    chk("abort_index", row_index, 3'd0);
    reset     = 1'b0;
    row_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done, 1'b0);
    run_stream(vecs[0], 1'b0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/silife_grid_reader.md
# silife_grid_reader

Snapshot-and-stream readout for the Game of Life cell matrix. On a `start` request it captures the matrix's flat `cells` vector in one cycle, then streams it out one row per transfer over a valid/ready handshake, so the matrix keeps evolving undisturbed. It also accumulates the live-cell population of the snapshot. It sits between the cell matrix output and any serial/display/host consumer.

## Interface
- `WIDTH`, default 8: cells per row; also the width of the row output word.
- `HEIGHT`, default 8: number of rows; must be ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a snapshot plus stream. Sampled only in IDLE.
- `cells`  in  WIDTH*HEIGHT  matrix state. Bit `y*WIDTH+x` is cell (x,y); row 0 is the top row.
- `busy`  out  1  high while a snapshot is being streamed.
- `row_data`  out  WIDTH  current row of the snapshot. Bit x is cell x.
- `row_index`  out  $clog2(HEIGHT)  index of the row on `row_data`.
- `row_last`  out  1  high with `row_valid` when `row_index == HEIGHT-1`.
- `row_valid`  out  1  row word available.
- `row_ready`  in  1  consumer accepts the word.
- `done`  out  1  one-cycle pulse after the last row is accepted.
- `live_count`  out  $clog2(WIDTH*HEIGHT+1)  live-cell total of the most recently completed snapshot.

## Operation
- States: IDLE and SEND.
- IDLE:
  - `row_valid` = 0 and `busy` = 0.
  - When `start` = 1: latch `cells` into `snap`, clear `row_ptr` and the accumulator `acc`, and go to SEND.
- SEND:
  - `row_valid` = 1 and `busy` = 1.
  - `row_data` = `snap[row_ptr*WIDTH +: WIDTH]`.
  - `row_index` = `row_ptr`.
- Transfer occurs on any cycle with `row_valid && row_ready`. On each transfer, `acc` increases by the popcount of `row_data`.
  - If `row_ptr` < HEIGHT-1: increment `row_ptr`.
  - If `row_ptr` = HEIGHT-1: go to IDLE, load `live_count` with the final accumulated value (including this row), and set `done` for the next cycle.
- Without a transfer, `row_data`, `row_index` and `row_last` hold stable. Consumer back-pressure is unbounded.
- `start` is ignored in SEND; it is not queued.
- `start` on the same cycle that `done` is high is honored, because the FSM is already in IDLE.
- `cells` changes after the capture cycle have no effect on the stream in progress.
- `live_count` holds its value until the next snapshot completes. It is not updated by an aborted snapshot.
- Width rule: `acc` and `live_count` are $clog2(WIDTH*HEIGHT+1) bits wide, so an all-live grid never wraps.

## Timing
- Reset values: state IDLE; `busy`, `row_valid`, `row_last`, `done` = 0; `row_data`, `row_index`, `live_count` = 0; `snap` = 0.
- Reset during SEND aborts the stream. All outputs take their reset values on the next cycle, and no `done` pulse is produced.
- `start` sampled at edge N → `row_valid` and `busy` high from cycle N+1.
- With `row_ready` held at 1: rows 0..HEIGHT-1 are presented in cycles N+1..N+HEIGHT.
- The cycle after the last transfer, N+HEIGHT+1: `done` = 1, `busy` = 0, `row_valid` = 0, and `live_count` is valid.
- Throughput: one row per cycle. Zero-bubble between rows.
- All outputs are registered or decoded directly from registered state. There is no combinational path from `row_ready` or `start` to any output.

## Structure
- Shared package `silife_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_SEND`);
  - helper localparam functions for the index width (`$clog2(HEIGHT)`) and the count width (`$clog2(WIDTH*HEIGHT+1)`).
- Sub-module `silife_popcount` #(`WIDTH`): combinational popcount of one row, output width $clog2(WIDTH+1). It is reused by later statistics blocks.
- Everything else lives in the top module: snapshot register, row pointer, FSM, accumulator.

## Test plan
- Glider: `cells` = 64'h0000_0000_0007_0402, `start` pulse, `row_ready` = 1.
  - Required rows: 0x02, 0x04, 0x07, then 0x00 ×5.
  - `row_last` high only with index 7.
  - `done` at cycle start+9; `live_count` = 5.
- Back-pressure: same grid, `row_ready` toggled 1,0,0,1,…
  - Every row is delivered exactly once and in order.
  - `row_data` and `row_index` stay stable during stalls.
  - `live_count` = 5.
- Snapshot isolation: change `cells` to all-ones on the cycle after `start`.
  - The stream still shows the glider rows; `live_count` = 5.
  - A second `start` then yields 0xFF ×8 and `live_count` = 64, with no wrap.
- Start while busy, and back-to-back starts:
  - `start` asserted during SEND is ignored; exactly 8 transfers and one `done` occur.
  - `start` asserted on the `done` cycle begins a new stream, with `row_valid` high the next cycle.
- Reset mid-stream: assert `reset` after 3 transfers.
  - Next cycle: `row_valid` = 0, `busy` = 0, no `done`, `live_count` = 0.
  - A subsequent `start` streams cleanly from row 0.
